module_deco_gray_sequencer: RTL and testbench

Control FSM that drives the gray-decoder display path at a fixed refresh rate. On each sample tick it synchronizes and decodes the gray input to binary, then starts a multi-cycle binary-to-BCD converter through a start/done handshake. It latches the BCD result for the 7-segment driver and flags converter timeouts. It sits between the switch inputs and the BCD converter and display driver in the top level.

---
 rtl/module_deco_gray_sequencer.sv | 139 +++++++++++++
 tb/tb_module_deco_gray_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/module_deco_gray_sequencer.sv
// Sample-tick sequencer for the gray-decoder display path: synchronizes and decodes the
// switch code, runs the BCD converter through a start/done handshake, and latches its result.
module module_deco_gray_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SAMPLE_PERIOD = 2700000,
    parameter int CONV_TIMEOUT  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] codigo_gray_i,
    output logic [WIDTH-1:0] bin_o,
    output logic             conv_start_o,
    input  logic             conv_done_i,
    input  logic [7:0]       bcd_i,
    output logic [7:0]       bcd_disp_o,
    output logic             disp_update_o,
    output logic             busy_o,
    output logic             error_o
);

    localparam int CNT_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int WCNT_W = $clog2(CONV_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(CONV_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        START,
        WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  tick_cnt_q;
    logic              tick;
    logic [WIDTH-1:0]  sync_q1, sync_q2;
    logic [WIDTH-1:0]  dec;
    logic [WCNT_W-1:0] wcnt_q;
    logic              have_value_q;

    logic load_bin, clr_wcnt, inc_wcnt, accept, timeout;

    // Two-flop synchronizer; the switches are asynchronous to clk_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= codigo_gray_i;
            sync_q2 <= sync_q1;
        end
    end

    assign tick = (tick_cnt_q == CNT_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i)     tick_cnt_q <= '0;
        else if (tick) tick_cnt_q <= '0;
        else           tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    // Each binary bit is the XOR of all gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_dec
            assign dec[gi] = ^sync_q2[WIDTH-1:gi];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        load_bin = 1'b0;
        clr_wcnt = 1'b0;
        inc_wcnt = 1'b0;
        accept   = 1'b0;
        timeout  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick) state_d = SAMPLE;
            end
            SAMPLE: begin
                load_bin = 1'b1;
                // An unchanged code is skipped unless the last conversion timed out.
                if (have_value_q && (dec == bin_o) && !error_o) state_d = IDLE;
                else                                            state_d = START;
            end
            START: begin
                clr_wcnt = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                inc_wcnt = 1'b1;
                if (conv_done_i) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end else if (wcnt_q == WCNT_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)         wcnt_q <= '0;
        else if (clr_wcnt) wcnt_q <= '0;
        else if (inc_wcnt) wcnt_q <= wcnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_o         <= '0;
            bcd_disp_o    <= 8'h00;
            disp_update_o <= 1'b0;
            error_o       <= 1'b0;
            have_value_q  <= 1'b0;
        end else begin
            disp_update_o <= accept;
            if (load_bin) bin_o <= dec;
            if (accept) begin
                bcd_disp_o   <= bcd_i;
                error_o      <= 1'b0;
                have_value_q <= 1'b1;
            end else if (timeout) begin
                error_o <= 1'b1;
            end
        end
    end

    assign conv_start_o = (state_q == START);
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_module_deco_gray_sequencer.sv
// Directed bench: per-tick vector table with a behavioural BCD converter, plus
// hand sequences for reset mid-conversion and input changes right at the tick.
module tb_module_deco_gray_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] codigo_gray_i;
    logic [3:0] bin_o;
    logic       conv_start_o;
    logic       conv_done_i;
    logic [7:0] bcd_i;
    logic [7:0] bcd_disp_o;
    logic       disp_update_o;
    logic       busy_o;
    logic       error_o;

    module_deco_gray_sequencer #(
        .WIDTH(4),
        .SAMPLE_PERIOD(8),
        .CONV_TIMEOUT(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .codigo_gray_i(codigo_gray_i),
        .bin_o(bin_o),
        .conv_start_o(conv_start_o),
        .conv_done_i(conv_done_i),
        .bcd_i(bcd_i),
        .bcd_disp_o(bcd_disp_o),
        .disp_update_o(disp_update_o),
        .busy_o(busy_o),
        .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] gray;
        int         dly;    // done this many cycles after start; 0 = never
        int         len;    // cycles done stays high
        bit         hi;     // done held high continuously
        logic [3:0] ebin;
        logic [7:0] ebcd;
        bit         eerr;
        int         estart;
        int         eupd;
        int         ebusy;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;
    int now = 0;
    int cyc = 0;
    bit armed = 0;
    int rfrom = 0, rto = 0;
    logic [7:0] rbcd = 8'h00;
    int cfg_dly = 3, cfg_len = 1;
    bit cfg_hi = 0;

    function automatic vec_t mk(input logic [3:0] g, input int d, input int l, input bit h,
                                input logic [3:0] eb, input logic [7:0] ed, input bit ee,
                                input int es, input int eu, input int ebz);
        vec_t v;
        v.gray = g; v.dly = d; v.len = l; v.hi = h;
        v.ebin = eb; v.ebcd = ed; v.eerr = ee;
        v.estart = es; v.eupd = eu; v.ebusy = ebz;
        return v;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [3:0] b);
        int v;
        v = int'(b);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: advance, then play the converter model for the new cycle.
    task automatic step();
        @(posedge clk_i);
        #1;
        now++;
        cyc++;
        if (conv_start_o === 1'b1) begin
            armed = 1;
            rfrom = now + cfg_dly;
            rto   = rfrom + cfg_len - 1;
            rbcd  = to_bcd(bin_o);
        end
        if (cfg_hi) begin
            conv_done_i = 1'b1;
            bcd_i       = to_bcd(bin_o);
        end else if (armed && cfg_dly > 0 && now >= rfrom && now <= rto) begin
            conv_done_i = 1'b1;
            bcd_i       = rbcd;
        end else begin
            conv_done_i = 1'b0;
            bcd_i       = 8'hEE;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bin"},   bin_o, 0);
        chk({tag, "_start"}, conv_start_o, 0);
        chk({tag, "_bcd"},   bcd_disp_o, 0);
        chk({tag, "_upd"},   disp_update_o, 0);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_err"},   error_o, 0);
    endtask

    initial begin
        int nb, ns, nu, so, uo;
        logic [3:0] sbin;

        vecs.push_back(mk(4'b0110, 3, 1, 0,  4, 8'h04, 0, 1, 1, 5));
        vecs.push_back(mk(4'b1000, 3, 1, 0, 15, 8'h15, 0, 1, 1, 5));
        vecs.push_back(mk(4'b1000, 3, 1, 0, 15, 8'h15, 0, 0, 0, 1));
        vecs.push_back(mk(4'b1000, 3, 1, 0, 15, 8'h15, 0, 0, 0, 1));
        vecs.push_back(mk(4'b1000, 3, 1, 0, 15, 8'h15, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0111, 0, 1, 0,  5, 8'h15, 1, 1, 0, 6));  // no response
        vecs.push_back(mk(4'b0111, 3, 1, 0,  5, 8'h05, 0, 1, 1, 5));  // retry clears error
        vecs.push_back(mk(4'b0111, 3, 1, 0,  5, 8'h05, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0111, 0, 1, 1,  5, 8'h05, 0, 0, 0, 1));  // done high while skipping
        vecs.push_back(mk(4'b0001, 0, 1, 1,  1, 8'h01, 0, 1, 1, 3));  // done high through START
        vecs.push_back(mk(4'b0011, 1, 1, 0,  2, 8'h02, 0, 1, 1, 3));
        vecs.push_back(mk(4'b0010, 4, 1, 0,  3, 8'h03, 0, 1, 1, 6));  // done on last WAIT cycle
        vecs.push_back(mk(4'b0110, 4, 4, 0,  4, 8'h04, 0, 1, 1, 6));  // stretched done
        vecs.push_back(mk(4'b0100, 5, 1, 0,  7, 8'h04, 1, 1, 0, 6));  // done after timeout
        vecs.push_back(mk(4'b1111, 3, 1, 0, 10, 8'h10, 0, 1, 1, 5));
        for (int g = 0; g < 16; g++)
            vecs.push_back(mk(4'(g), 3, 1, 0, g2b(4'(g)), to_bcd(g2b(4'(g))), 0, 1, 1, 5));

        codigo_gray_i = vecs[0].gray;
        conv_done_i   = 1'b0;
        bcd_i         = 8'h00;
        rst_i         = 1'b1;
        repeat (3) step();
        rst_i = 1'b0;
        cyc   = 0;
        check_zero("reset");

        nb = 0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (busy_o !== 1'b0) nb++;
        end
        chk("pre_tick_busy", nb, 0);

        // Each window starts in a tick cycle and ends in the next one.
        for (int i = 0; i < vecs.size(); i++) begin
            cfg_dly = vecs[i].dly;
            cfg_len = vecs[i].len;
            cfg_hi  = vecs[i].hi;
            if (cfg_hi) conv_done_i = 1'b1;
            nb = 0; ns = 0; nu = 0; so = -1; uo = -1; sbin = 4'h0;
            for (int k = 1; k <= 8; k++) begin
                step();
                if (k == 1 && i + 1 < vecs.size()) codigo_gray_i = vecs[i+1].gray;
                if (busy_o === 1'b1) nb++;
                if (conv_start_o === 1'b1) begin ns++; so = k; sbin = bin_o; end
                if (disp_update_o === 1'b1) begin nu++; uo = k; end
            end
            chk($sformatf("v%0d_bin", i),    bin_o, vecs[i].ebin);
            chk($sformatf("v%0d_bcd", i),    bcd_disp_o, vecs[i].ebcd);
            chk($sformatf("v%0d_err", i),    error_o, vecs[i].eerr);
            chk($sformatf("v%0d_starts", i), ns, vecs[i].estart);
            chk($sformatf("v%0d_upds", i),   nu, vecs[i].eupd);
            chk($sformatf("v%0d_busycyc", i), nb, vecs[i].ebusy);
            chk($sformatf("v%0d_idle", i),   busy_o, 0);
            if (ns > 0 && vecs[i].estart > 0) begin
                chk($sformatf("v%0d_start_off", i), so, 2);
                chk($sformatf("v%0d_start_bin", i), sbin, vecs[i].ebin);
            end
            if (nu > 0 && vecs[i].eupd > 0)
                chk($sformatf("v%0d_upd_off", i), uo, vecs[i].ebusy + 1);
        end

        // Reset during WAIT: everything clears, a late done is ignored, tick restarts.
        codigo_gray_i = 4'b0101;
        cfg_dly = 3; cfg_len = 1; cfg_hi = 0;
        repeat (11) step();
        chk("r_in_wait", busy_o, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        cyc   = 0;
        check_zero("r_mid");
        nb = 0; nu = 0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (busy_o !== 1'b0) nb++;
            if (disp_update_o !== 1'b0) nu++;
        end
        chk("r_post_busy", nb, 0);
        chk("r_post_upd", nu, 0);
        chk("r_post_bcd", bcd_disp_o, 8'h00);
        step();
        chk("r_tick_at_8", busy_o, 1);
        repeat (7) step();
        chk("r_conv_bin", bin_o, 4'd6);
        chk("r_conv_bcd", bcd_disp_o, 8'h06);
        chk("r_conv_err", error_o, 0);

        // Input changed in the tick cycle is not yet through the synchronizer.
        codigo_gray_i = 4'b1100;
        ns = 0; sbin = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (conv_start_o === 1'b1) ns++;
            if (k == 2) sbin = bin_o;
        end
        chk("sync_pre_bin", sbin, 4'd6);
        chk("sync_pre_starts", ns, 0);
        repeat (8) step();
        chk("sync_post_bin", bin_o, 4'd8);
        chk("sync_post_bcd", bcd_disp_o, 8'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
